// File: rtl/minibyte_pkg.sv
// Shared definitions for the minibyte ALU: opcodes, FSM states and flag bit positions.
package minibyte_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/minibyte_alu_if.sv
// Request/response bundle between the minibyte datapath and its ALU.
interface minibyte_alu_if #(parameter int WIDTH = 8);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;
    logic             err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, result_hi, flags, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, result_hi, flags, err
    );
endinterface

// File: rtl/minibyte_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per clock.
// Only built when MINIBYTE_MUL_EN is defined.
`ifdef MINIBYTE_MUL_EN
module minibyte_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               step_done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH:0]   sum;

    // prod is the value {hi,lo} takes at the coming edge, so the caller can
    // capture the finished product on the same edge as the last step.
    always_comb begin
        sum       = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        prod      = {sum, lo[WIDTH-1:1]};
        step_done = run && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (load) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            run   <= 1'b1;
        end else if (run) begin
            {hi, lo} <= prod;
            cnt      <= cnt + 1'b1;
            if (step_done)
                run <= 1'b0;
        end
    end
endmodule
`endif

// File: rtl/minibyte_alu.sv
// Registered minibyte ALU with start/busy/done handshake and Z/N/C/V flags.
// Sequential multiply is built only when MINIBYTE_MUL_EN is defined.
module minibyte_alu
    import minibyte_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    minibyte_alu_if.slave  bus
);
    logic [WIDTH-1:0] sc_res;
    logic [3:0]       sc_flags;
    logic             sc_c, sc_v, sc_err;
    logic [WIDTH:0]   ext;
    logic             busy;
    logic             accept_sc;
    logic             mul_fin;
    logic [WIDTH-1:0] mul_lo, mul_hi;
    logic [3:0]       mul_flags;

    logic [WIDTH-1:0] result_q, result_hi_q;
    logic [3:0]       flags_q;
    logic             err_q, done_q;

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        ext    = '0;
        case (bus.op)
            OP_ADD: begin
                ext    = {1'b0, bus.a} + {1'b0, bus.b};
                sc_res = ext[WIDTH-1:0];
                sc_c   = ext[WIDTH];
                sc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra bit of the difference is the borrow, i.e. a < b.
                ext    = {1'b0, bus.a} - {1'b0, bus.b};
                sc_res = ext[WIDTH-1:0];
                sc_c   = ext[WIDTH];
                sc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:   sc_res = bus.a & bus.b;
            OP_OR:    sc_res = bus.a | bus.b;
            OP_XOR:   sc_res = bus.a ^ bus.b;
            OP_NOT:   sc_res = ~bus.a;
            OP_SHL: begin
                sc_res = {bus.a[WIDTH-2:0], 1'b0};
                sc_c   = bus.a[WIDTH-1];
            end
            OP_SHR: begin
                sc_res = {1'b0, bus.a[WIDTH-1:1]};
                sc_c   = bus.a[0];
            end
            OP_PASSB: sc_res = bus.b;
            default:  sc_err = 1'b1;
        endcase
        sc_flags = '0;
        if (!sc_err) begin
            sc_flags[FLAG_Z] = (sc_res == '0);
            sc_flags[FLAG_N] = sc_res[WIDTH-1];
            sc_flags[FLAG_C] = sc_c;
            sc_flags[FLAG_V] = sc_v;
        end
    end

`ifdef MINIBYTE_MUL_EN
    state_t             state, state_nxt;
    logic               mul_load;
    logic               step_done;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start && bus.op == OP_MUL) state_nxt = ST_MUL;
            ST_MUL:  if (step_done)                     state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_MUL);
        mul_load  = (state == ST_IDLE) && bus.start && (bus.op == OP_MUL);
        accept_sc = (state == ST_IDLE) && bus.start && (bus.op != OP_MUL);
        mul_fin   = (state == ST_MUL) && step_done;
    end

    minibyte_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .load      (mul_load),
        .a         (bus.a),
        .b         (bus.b),
        .step_done (step_done),
        .prod      (prod)
    );

    assign mul_lo = prod[WIDTH-1:0];
    assign mul_hi = prod[2*WIDTH-1:WIDTH];
`else
    // Opcode 8 falls into the illegal branch of the single-cycle decoder.
    assign busy      = 1'b0;
    assign accept_sc = bus.start;
    assign mul_fin   = 1'b0;
    assign mul_lo    = '0;
    assign mul_hi    = '0;
`endif

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_lo == '0) && (mul_hi == '0);
        mul_flags[FLAG_N] = mul_lo[WIDTH-1];
        mul_flags[FLAG_C] = |mul_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept_sc) begin
                result_q    <= sc_res;
                result_hi_q <= '0;
                flags_q     <= sc_flags;
                err_q       <= sc_err;
                done_q      <= 1'b1;
            end else if (mul_fin) begin
                result_q    <= mul_lo;
                result_hi_q <= mul_hi;
                flags_q     <= mul_flags;
                err_q       <= 1'b0;
                done_q      <= 1'b1;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flags     = flags_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_minibyte_alu.sv
// Directed vector bench for minibyte_alu at WIDTH=8; MUL cases follow MINIBYTE_MUL_EN.
module tb_minibyte_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    minibyte_alu_if #(.WIDTH(8)) bus ();

    minibyte_alu #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;
        logic       err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    task automatic check_sc(input string name, input logic [7:0] res, input logic [3:0] flg, input logic err);
        chk({name, ".done"}, 32'(bus.done), 32'd1);
        chk({name, ".busy"}, 32'(bus.busy), 32'd0);
        chk({name, ".res"},  32'(bus.result), 32'(res));
        chk({name, ".hi"},   32'(bus.result_hi), 32'd0);
        chk({name, ".flags"}, 32'(bus.flags), 32'(flg));
        chk({name, ".err"},  32'(bus.err), 32'(err));
    endtask

    initial begin
        int cyc;
        //        op     a      b      res    ZNCV     err
        vecs[0]  = '{4'd0, 8'hFF, 8'h01, 8'h00, 4'b1010, 1'b0};
        vecs[1]  = '{4'd1, 8'h80, 8'h01, 8'h7F, 4'b0001, 1'b0};
        vecs[2]  = '{4'd1, 8'h01, 8'h02, 8'hFF, 4'b0110, 1'b0};
        vecs[3]  = '{4'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0};
        vecs[4]  = '{4'd3, 8'h0F, 8'h30, 8'h3F, 4'b0000, 1'b0};
        vecs[5]  = '{4'd4, 8'hAA, 8'hAA, 8'h00, 4'b1000, 1'b0};
        vecs[6]  = '{4'd5, 8'h55, 8'h00, 8'hAA, 4'b0100, 1'b0};
        vecs[7]  = '{4'd6, 8'h81, 8'h00, 8'h02, 4'b0010, 1'b0};
        vecs[8]  = '{4'd7, 8'h81, 8'h00, 8'h40, 4'b0010, 1'b0};
        vecs[9]  = '{4'd9, 8'h12, 8'h80, 8'h80, 4'b0100, 1'b0};
        vecs[10] = '{4'd12, 8'h34, 8'h56, 8'h00, 4'b0000, 1'b1};
        vecs[11] = '{4'd0, 8'h7F, 8'h01, 8'h80, 4'b0101, 1'b0};
        vecs[12] = '{4'd1, 8'h05, 8'h05, 8'h00, 4'b1000, 1'b0};

        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        rst       = 1'b1;
        // start held during reset must be ignored
        drive(4'd9, 8'h00, 8'h5A);
        tick();
        tick();
        chk("rst.done",  32'(bus.done), 32'd0);
        chk("rst.busy",  32'(bus.busy), 32'd0);
        chk("rst.res",   32'(bus.result), 32'd0);
        chk("rst.hi",    32'(bus.result_hi), 32'd0);
        chk("rst.flags", 32'(bus.flags), 32'd0);
        chk("rst.err",   32'(bus.err), 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        tick();

        // back-to-back issue, one per clock
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            check_sc($sformatf("vec%0d", i), vecs[i].res, vecs[i].flg, vecs[i].err);
        end
        bus.start = 1'b0;
        tick();
        chk("hold.done",  32'(bus.done), 32'd0);
        chk("hold.res",   32'(bus.result), 32'h00);
        chk("hold.flags", 32'(bus.flags), 32'b1000);

`ifdef MINIBYTE_MUL_EN
        // MUL 0x10*0x10 with an ignored ADD during busy
        drive(4'd8, 8'h10, 8'h10);
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("mul.busy%0d", k), 32'(bus.busy), 32'd1);
            chk($sformatf("mul.done%0d", k), 32'(bus.done), 32'd0);
            if (k == 3) drive(4'd0, 8'h01, 8'h01);
            if (k == 4) bus.start = 1'b0;
            tick();
        end
        chk("mul.done", 32'(bus.done), 32'd1);
        chk("mul.busy", 32'(bus.busy), 32'd0);
        chk("mul.res",  32'(bus.result), 32'h00);
        chk("mul.hi",   32'(bus.result_hi), 32'h01);
        chk("mul.flags", 32'(bus.flags), 32'b0010);
        chk("mul.err",  32'(bus.err), 32'd0);
        tick();
        chk("mul.nodup", 32'(bus.done), 32'd0);
        chk("mul.holdhi", 32'(bus.result_hi), 32'h01);

        // reset in the middle of a multiply
        drive(4'd8, 8'h0F, 8'h11);
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.hi",   32'(bus.result_hi), 32'd0);
        chk("abort.flags", 32'(bus.flags), 32'd0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("abort.done%0d", k), 32'(bus.done), 32'd0);
            tick();
        end

        drive(4'd8, 8'h0F, 8'h11);
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("mul2.latency", 32'(cyc), 32'd9);
        chk("mul2.res",   32'(bus.result), 32'hFF);
        chk("mul2.hi",    32'(bus.result_hi), 32'h00);
        chk("mul2.flags", 32'(bus.flags), 32'b0100);
`else
        drive(4'd8, 8'h10, 8'h10);
        tick();
        bus.start = 1'b0;
        check_sc("mul_off", 8'h00, 4'b0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mul_off.busy%0d", k), 32'(bus.busy), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
